// File: rtl/axil_reg_wr_arb_pkg.sv
// Shared definitions for the register-interface arbiter family:
// arbitration state encoding and a width helper that never returns zero.
package axil_reg_wr_arb_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_t;

   // $clog2 of 1 is 0, which cannot size a vector; clamp to one bit
   function automatic int clog2_min1(input int value);
      int width;
      width = $clog2(value);
      return (width < 1) ? 1 : width;
   endfunction

endpackage

// File: rtl/axil_reg_wr_arb_rr.sv
// Combinational round-robin priority encoder: picks the first requester
// strictly after last_idx, wrapping modulo PORTS.
module reg_rr_arb
   import axil_reg_wr_arb_pkg::*;
#(
   parameter int PORTS = 4,
   parameter int IDX_W = clog2_min1(PORTS)
) (
   input  logic [PORTS-1:0] req,
   input  logic [IDX_W-1:0] last_idx,
   output logic             grant_valid,
   output logic [IDX_W-1:0] grant_idx
);

   int best_off;
   int off;

   // Distance of port j from last_idx; the smallest distance wins, so
   // last_idx itself (distance PORTS-1) has the lowest priority
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      best_off    = PORTS;
      off         = 0;
      for (int j = 0; j < PORTS; j++) begin
         off = (j + PORTS - int'(last_idx) - 1) % PORTS;
         if (req[j] && (off < best_off)) begin
            best_off    = off;
            grant_valid = 1'b1;
            grant_idx   = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/axil_reg_wr_arb.sv
// Round-robin arbiter sharing one downstream register write port among
// PORTS requesters; one write per grant, completed by ack or local timeout.
module axil_reg_wr_arb
   import axil_reg_wr_arb_pkg::*;
#(
   parameter int PORTS      = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int TIMEOUT    = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,

   input  logic [PORTS*ADDR_WIDTH-1:0] s_reg_wr_addr,
   input  logic [PORTS*DATA_WIDTH-1:0] s_reg_wr_data,
   input  logic [PORTS*STRB_WIDTH-1:0] s_reg_wr_strb,
   input  logic [PORTS-1:0]            s_reg_wr_en,
   output logic [PORTS-1:0]            s_reg_wr_wait,
   output logic [PORTS-1:0]            s_reg_wr_ack,

   output logic [ADDR_WIDTH-1:0]       m_reg_wr_addr,
   output logic [DATA_WIDTH-1:0]       m_reg_wr_data,
   output logic [STRB_WIDTH-1:0]       m_reg_wr_strb,
   output logic                        m_reg_wr_en,
   input  logic                        m_reg_wr_wait,
   input  logic                        m_reg_wr_ack
);

   localparam int IDX_W = clog2_min1(PORTS);
   localparam int CNT_W = clog2_min1(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(PORTS - 1);

   arb_state_t       state;
   arb_state_t       state_nxt;
   logic [IDX_W-1:0] grant_idx;
   logic [IDX_W-1:0] grant_nxt;
   logic [IDX_W-1:0] last_idx;
   logic [IDX_W-1:0] last_nxt;
   logic [CNT_W-1:0] timeout_cnt;
   logic [CNT_W-1:0] cnt_nxt;

   logic             rr_valid;
   logic [IDX_W-1:0] rr_idx;
   logic [PORTS-1:0] grant_onehot;
   logic [PORTS-1:0] busy_onehot;
   logic             busy;
   logic             granted_en;
   logic             done;
   logic             abort;

   reg_rr_arb #(
      .PORTS (PORTS),
      .IDX_W (IDX_W)
   ) u_rr (
      .req         (s_reg_wr_en),
      .last_idx    (last_idx),
      .grant_valid (rr_valid),
      .grant_idx   (rr_idx)
   );

   always_comb begin
      grant_onehot = '0;
      for (int i = 0; i < PORTS; i++) begin
         grant_onehot[i] = (grant_idx == IDX_W'(i));
      end
   end

   // An abort (requester dropped en) takes precedence over completion, so a
   // requester that has gone away never sees a stray ack
   assign busy        = (state == ST_BUSY);
   assign busy_onehot = {PORTS{busy}} & grant_onehot;
   assign granted_en  = |(s_reg_wr_en & grant_onehot);
   assign done        = busy && granted_en && (m_reg_wr_ack || (timeout_cnt == '0));
   assign abort       = busy && !granted_en;

   assign m_reg_wr_en   = busy;
   assign s_reg_wr_ack  = done ? grant_onehot : '0;
   assign s_reg_wr_wait = (s_reg_wr_en & ~busy_onehot)
                        | (m_reg_wr_wait ? busy_onehot : '0);

   always_comb begin
      m_reg_wr_addr = '0;
      m_reg_wr_data = '0;
      m_reg_wr_strb = '0;
      for (int i = 0; i < PORTS; i++) begin
         if (grant_onehot[i]) begin
            m_reg_wr_addr = s_reg_wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            m_reg_wr_data = s_reg_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            m_reg_wr_strb = s_reg_wr_strb[i*STRB_WIDTH +: STRB_WIDTH];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      grant_nxt = grant_idx;
      last_nxt  = last_idx;
      cnt_nxt   = timeout_cnt;
      unique case (state)
         ST_IDLE: begin
            if (rr_valid) begin
               grant_nxt = rr_idx;
               cnt_nxt   = CNT_LOAD;
               state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (abort || done) begin
               last_nxt  = grant_idx;
               state_nxt = ST_IDLE;
            end else if (!m_reg_wr_wait && (timeout_cnt != '0)) begin
               cnt_nxt = timeout_cnt - CNT_W'(1);
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         grant_idx   <= '0;
         last_idx    <= LAST_RESET;
         timeout_cnt <= '0;
      end else begin
         state       <= state_nxt;
         grant_idx   <= grant_nxt;
         last_idx    <= last_nxt;
         timeout_cnt <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_axil_reg_wr_arb.sv
// Directed bench for axil_reg_wr_arb: expected writes are queued as requests
// are raised and matched against every upstream ack pulse.
module tb_axil_reg_wr_arb;

   localparam int PORTS = 4;
   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int SW    = DW / 8;
   localparam int TO    = 4;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [PORTS*AW-1:0]  s_addr;
   logic [PORTS*DW-1:0]  s_data;
   logic [PORTS*SW-1:0]  s_strb;
   logic [PORTS-1:0]     s_en;
   logic [PORTS-1:0]     s_wait;
   logic [PORTS-1:0]     s_ack;
   logic [AW-1:0]        m_addr;
   logic [DW-1:0]        m_data;
   logic [SW-1:0]        m_strb;
   logic                 m_en;
   logic                 m_wait;
   logic                 m_ack;

   always #5 clk = ~clk;

   axil_reg_wr_arb #(
      .PORTS      (PORTS),
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .STRB_WIDTH (SW),
      .TIMEOUT    (TO)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_reg_wr_addr (s_addr),
      .s_reg_wr_data (s_data),
      .s_reg_wr_strb (s_strb),
      .s_reg_wr_en   (s_en),
      .s_reg_wr_wait (s_wait),
      .s_reg_wr_ack  (s_ack),
      .m_reg_wr_addr (m_addr),
      .m_reg_wr_data (m_data),
      .m_reg_wr_strb (m_strb),
      .m_reg_wr_en   (m_en),
      .m_reg_wr_wait (m_wait),
      .m_reg_wr_ack  (m_ack)
   );

   typedef struct {
      int            port;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [SW-1:0] strb;
   } exp_t;

   exp_t             sb_q[$];
   int               total = 0;
   int               bad = 0;
   int               ack_pulses = 0;
   logic [PORTS-1:0] drop_on_ack = '1;
   logic [PORTS-1:0] pending_drop = '0;

   logic             snap_m_en;
   logic [AW-1:0]    snap_m_addr;
   logic [DW-1:0]    snap_m_data;
   logic [PORTS-1:0] snap_s_ack;
   logic [PORTS-1:0] snap_s_wait;

   function automatic logic [AW-1:0] port_addr(input int p);
      return AW'(32'h0000_0100 + p * 4);
   endfunction

   function automatic logic [DW-1:0] port_data(input int p);
      return DW'(32'hA5A5_0000 + p);
   endfunction

   task automatic check_output(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic set_req(input int p, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [SW-1:0] s);
      s_addr[p*AW +: AW] = a;
      s_data[p*DW +: DW] = d;
      s_strb[p*SW +: SW] = s;
      s_en[p]            = 1'b1;
   endtask

   task automatic push_exp(input int p, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
      exp_t e;
      e.port = p;
      e.addr = a;
      e.data = d;
      e.strb = s;
      sb_q.push_back(e);
   endtask

   task automatic apply_stimulus(input logic ack, input logic dn_wait);
      m_ack  = ack;
      m_wait = dn_wait;
   endtask

   // Every ack pulse must match the oldest outstanding expected write
   task automatic sb_monitor();
      exp_t e;
      if (snap_s_ack != '0) begin
         ack_pulses += $countones(snap_s_ack);
         if (sb_q.size() == 0) begin
            check_output("sb_unexpected_ack", 64'(snap_s_ack), 64'd0);
         end else begin
            e = sb_q.pop_front();
            check_output("sb_ack_port", 64'(snap_s_ack), 64'd1 << e.port);
            check_output("sb_addr", 64'(m_addr), 64'(e.addr));
            check_output("sb_data", 64'(m_data), 64'(e.data));
            check_output("sb_strb", 64'(m_strb), 64'(e.strb));
         end
         pending_drop = pending_drop | (snap_s_ack & drop_on_ack);
      end
   endtask

   // Called at a falling edge: samples the current cycle, then lets requesters
   // that saw an ack drop en just after the rising edge
   task automatic tick();
      #2;
      snap_m_en   = m_en;
      snap_m_addr = m_addr;
      snap_m_data = m_data;
      snap_s_ack  = s_ack;
      snap_s_wait = s_wait;
      sb_monitor();
      @(posedge clk);
      #1;
      s_en         = s_en & ~pending_drop;
      pending_drop = '0;
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int rr_order[5];
      int acks_before;
      rr_order = '{0, 1, 2, 3, 0};

      rst_n  = 1'b0;
      s_addr = '0;
      s_data = '0;
      s_strb = '0;
      s_en   = '0;
      apply_stimulus(1'b0, 1'b0);
      repeat (2) @(negedge clk);

      $display("[TB] reset state");
      s_en = 4'b0101;
      #2;
      check_output("rst_m_en", 64'(m_en), 64'd0);
      check_output("rst_s_ack", 64'(s_ack), 64'd0);
      check_output("rst_s_wait", 64'(s_wait), 64'b0101);
      s_en = '0;
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] round-robin fairness");
      for (int p = 0; p < PORTS; p++) set_req(p, port_addr(p), port_data(p), 4'hF);
      foreach (rr_order[k]) push_exp(rr_order[k], port_addr(rr_order[k]),
                                     port_data(rr_order[k]), 4'hF);
      drop_on_ack = '0;
      apply_stimulus(1'b1, 1'b0);
      for (int k = 0; k < 10; k++) begin
         tick();
         if (k % 2 == 0) begin
            check_output("rr_idle_m_en", 64'(snap_m_en), 64'd0);
            check_output("rr_idle_wait", 64'(snap_s_wait), 64'hF);
         end else begin
            check_output("rr_busy_m_en", 64'(snap_m_en), 64'd1);
            check_output("rr_busy_wait", 64'(snap_s_wait),
                         64'hF & ~(64'd1 << rr_order[k/2]));
         end
      end
      s_en        = '0;
      drop_on_ack = '1;
      tick();
      check_output("rr_end_m_en", 64'(snap_m_en), 64'd0);

      $display("[TB] single request on port 2");
      apply_stimulus(1'b0, 1'b0);
      set_req(2, 32'h10, 32'hDEAD_BEEF, 4'hF);
      push_exp(2, 32'h10, 32'hDEAD_BEEF, 4'hF);
      tick();
      check_output("single_idle_m_en", 64'(snap_m_en), 64'd0);
      check_output("single_idle_wait", 64'(snap_s_wait), 64'b0100);
      apply_stimulus(1'b1, 1'b0);
      tick();
      check_output("single_m_en", 64'(snap_m_en), 64'd1);
      check_output("single_addr", 64'(snap_m_addr), 64'h10);
      check_output("single_data", 64'(snap_m_data), 64'hDEAD_BEEF);
      check_output("single_ack", 64'(snap_s_ack), 64'b0100);
      check_output("single_wait", 64'(snap_s_wait), 64'b0000);
      tick();
      check_output("single_after_m_en", 64'(snap_m_en), 64'd0);
      check_output("idle_ack_ignored", 64'(snap_s_ack), 64'd0);

      $display("[TB] timeout without downstream wait");
      apply_stimulus(1'b0, 1'b0);
      set_req(0, 32'h20, 32'h1234_5678, 4'h3);
      push_exp(0, 32'h20, 32'h1234_5678, 4'h3);
      tick();
      for (int c = 1; c <= TO; c++) begin
         tick();
         check_output("to_m_en", 64'(snap_m_en), 64'd1);
         check_output("to_ack", 64'(snap_s_ack), (c == TO) ? 64'b0001 : 64'd0);
      end
      tick();
      check_output("to_after_m_en", 64'(snap_m_en), 64'd0);

      $display("[TB] timeout frozen by downstream wait");
      set_req(1, 32'h24, 32'h0BAD_F00D, 4'hC);
      push_exp(1, 32'h24, 32'h0BAD_F00D, 4'hC);
      tick();
      apply_stimulus(1'b0, 1'b1);
      for (int c = 0; c < 10; c++) begin
         tick();
         check_output("tow_ack", 64'(snap_s_ack), 64'd0);
         check_output("tow_wait", 64'(snap_s_wait), 64'b0010);
      end
      apply_stimulus(1'b0, 1'b0);
      for (int c = 1; c <= TO; c++) begin
         tick();
         check_output("tow_release_ack", 64'(snap_s_ack), (c == TO) ? 64'b0010 : 64'd0);
      end

      $display("[TB] ack coinciding with timeout");
      set_req(2, 32'h30, 32'hCAFE_0001, 4'hF);
      push_exp(2, 32'h30, 32'hCAFE_0001, 4'hF);
      tick();
      acks_before = ack_pulses;
      for (int c = 1; c < TO; c++) tick();
      apply_stimulus(1'b1, 1'b0);
      tick();
      check_output("both_ack", 64'(snap_s_ack), 64'b0100);
      tick();
      check_output("both_idle_m_en", 64'(snap_m_en), 64'd0);
      check_output("both_idle_ack", 64'(snap_s_ack), 64'd0);
      check_output("both_pulse_count", 64'(ack_pulses - acks_before), 64'd1);
      apply_stimulus(1'b0, 1'b0);

      $display("[TB] abort by port 1");
      set_req(1, 32'h40, 32'h1111_1111, 4'hF);
      set_req(2, 32'h44, 32'h2222_2222, 4'h1);
      push_exp(2, 32'h44, 32'h2222_2222, 4'h1);
      tick();
      tick();
      check_output("abort_m_en", 64'(snap_m_en), 64'd1);
      check_output("abort_addr", 64'(snap_m_addr), 64'h40);
      s_en[1] = 1'b0;
      tick();
      check_output("abort_no_ack", 64'(snap_s_ack), 64'd0);
      tick();
      check_output("abort_idle_m_en", 64'(snap_m_en), 64'd0);
      apply_stimulus(1'b1, 1'b0);
      tick();
      check_output("abort_next_addr", 64'(snap_m_addr), 64'h44);
      check_output("abort_next_ack", 64'(snap_s_ack), 64'b0100);
      apply_stimulus(1'b0, 1'b0);

      $display("[TB] reset while port 3 is granted");
      set_req(3, 32'h50, 32'h3333_3333, 4'hF);
      tick();
      #2;
      check_output("rstmid_before", 64'(m_en), 64'd1);
      rst_n = 1'b0;
      #1;
      check_output("rstmid_m_en", 64'(m_en), 64'd0);
      apply_stimulus(1'b1, 1'b0);
      #1;
      check_output("rstmid_ack", 64'(s_ack), 64'd0);
      apply_stimulus(1'b0, 1'b0);
      repeat (2) @(negedge clk);
      set_req(1, 32'h60, 32'h6666_6666, 4'h7);
      push_exp(1, 32'h60, 32'h6666_6666, 4'h7);
      push_exp(3, 32'h50, 32'h3333_3333, 4'hF);
      rst_n = 1'b1;
      tick();
      apply_stimulus(1'b1, 1'b0);
      tick();
      check_output("rstmid_first_ack", 64'(snap_s_ack), 64'b0010);
      tick();
      tick();
      check_output("rstmid_second_ack", 64'(snap_s_ack), 64'b1000);
      apply_stimulus(1'b0, 1'b0);
      tick();
      check_output("end_m_en", 64'(snap_m_en), 64'd0);
      check_output("sb_empty", 64'(sb_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
